vending_machine: RTL and testbench

Single-clock vending-machine controller for an 8-product machine. It takes a per-product price and stock vector, the customer's product selection, and either a prepaid credit balance or cash coins. It decides when to dispense and returns change as quarter/dime/nickel counts. It sits between the coin acceptor / card reader front end and the dispense and coin-return actuators.

---
 rtl/vending_pkg.sv | 33 +++
 rtl/vending_machine_change_maker.sv | 22 ++
 rtl/vending_machine.sv | 158 +++++++++++++++
 tb/tb_vending_machine.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/vending_pkg.sv
// Shared types and constants for the vending machine controller.
package vending_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    COLLECT  = 2'd1,
    DISPENSE = 2'd2,
    CHANGE   = 2'd3
  } state_t;

  localparam int NUM_PRODUCTS = 8;
  localparam int PRICE_W      = 8;
  localparam int STOCK_W      = 3;
  localparam int BAL_W        = 9;

  localparam logic [BAL_W-1:0] NICKEL_VAL  = 9'd5;
  localparam logic [BAL_W-1:0] DIME_VAL    = 9'd10;
  localparam logic [BAL_W-1:0] QUARTER_VAL = 9'd25;
  localparam logic [BAL_W-1:0] DOLLAR_VAL  = 9'd100;
  localparam logic [BAL_W-1:0] CASH_CAP    = 9'd500;

  // Edge bits ordered {dollar, quarter, dime, nickel}; simultaneous edges add up.
  function automatic logic [BAL_W-1:0] coin_value(input logic [3:0] edges);
    logic [BAL_W-1:0] sum;
    sum = '0;
    if (edges[0]) sum = sum + NICKEL_VAL;
    if (edges[1]) sum = sum + DIME_VAL;
    if (edges[2]) sum = sum + QUARTER_VAL;
    if (edges[3]) sum = sum + DOLLAR_VAL;
    return sum;
  endfunction

endpackage

// File: rtl/vending_machine_change_maker.sv
// Greedy split of a cent amount into quarter/dime/nickel counts; sub-nickel remainder is dropped.
module change_maker
  import vending_pkg::*;
(
  input  logic [8:0] amount,
  output logic [8:0] quart,
  output logic [8:0] dim,
  output logic [8:0] nick
);

  logic [8:0] rem_q;
  logic [8:0] rem_d;

  always_comb begin
    quart = amount / QUARTER_VAL;
    rem_q = amount % QUARTER_VAL;
    dim   = rem_q / DIME_VAL;
    rem_d = rem_q % DIME_VAL;
    nick  = rem_d / NICKEL_VAL;
  end

endmodule

// File: rtl/vending_machine.sv
// Vending controller: credit or cash payment, per-product stock and price, coin change return.
module vending_machine
  import vending_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  se,
  input  logic [5:0]  si,
  input  logic [3:0]  index,
  input  logic        paymentMethod,
  input  logic [8:0]  creditBalance,
  input  logic        nickel,
  input  logic        dime,
  input  logic        quarter,
  input  logic        dollar,
  input  logic [63:0] cost,
  input  logic        cancel,
  input  logic [23:0] currentInventory,
  output logic [8:0]  quart,
  output logic [8:0]  dim,
  output logic [8:0]  nick,
  output logic        dispensed
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO = TW'(TIMEOUT_CYCLES);

  state_t state, state_nxt;

  logic [NUM_PRODUCTS-1:0][STOCK_W-1:0] stock;
  logic [BAL_W-1:0] credit, cash, chg_amt, chg_val;
  logic [TW-1:0]    timer;
  logic             armed;
  logic [3:0]       prev_coins, coin_edge;
  logic [3:0]       prev_index;
  logic             prev_pm;

  logic [2:0]         sel;
  logic [PRICE_W-1:0] price;
  logic [BAL_W-1:0]   coin_sum;
  logic               coin_ok, sel_ok, cash_sale, credit_sale, changed;
  logic               vend, credit_vend, chg_set, arm_clr;
  logic [8:0]         cm_q, cm_d, cm_n;
  logic               unused_dft;

  assign unused_dft = ^{se, si};

  always_comb begin
    sel         = index[2:0];
    price       = cost[{sel, 3'b000} +: PRICE_W];
    sel_ok      = (index < 4'd8) && (stock[sel] != '0);
    cash_sale   = sel_ok && (cash >= {1'b0, price});
    credit_sale = sel_ok && (credit >= {1'b0, price});
    changed     = (index != prev_index) || (paymentMethod != prev_pm);
    coin_edge   = {dollar, quarter, dime, nickel} & ~prev_coins;
    coin_sum    = coin_value(coin_edge);
    // COLLECT accepts coins regardless of paymentMethod; IDLE only in cash mode.
    coin_ok     = ((state == IDLE && !paymentMethod) || state == COLLECT) &&
                  (coin_edge != 4'b0000) &&
                  (({1'b0, cash} + {1'b0, coin_sum}) <= {1'b0, CASH_CAP});
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    vend        = 1'b0;
    credit_vend = 1'b0;
    chg_set     = 1'b0;
    chg_val     = chg_amt;
    arm_clr     = 1'b0;
    unique case (state)
      IDLE: begin
        if (paymentMethod) begin
          if (armed) begin
            arm_clr = 1'b1;
            if (credit_sale) begin
              vend        = 1'b1;
              credit_vend = 1'b1;
              chg_set     = 1'b1;
              chg_val     = '0;
              state_nxt   = DISPENSE;
            end
          end
        end else if (coin_ok) begin
          state_nxt = COLLECT;
        end
      end
      COLLECT: begin
        if (cash_sale) begin
          vend      = 1'b1;
          chg_set   = 1'b1;
          chg_val   = cash - {1'b0, price};
          state_nxt = DISPENSE;
        end else if (cancel || timer == TMO) begin
          chg_set   = 1'b1;
          chg_val   = cash;
          state_nxt = CHANGE;
        end
      end
      DISPENSE: state_nxt = CHANGE;
      CHANGE:   state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  always_comb begin
    dispensed = (state == DISPENSE);
  end

  change_maker u_change_maker (
    .amount (chg_amt),
    .quart  (cm_q),
    .dim    (cm_d),
    .nick   (cm_n)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      stock      <= currentInventory;
      credit     <= creditBalance;
      cash       <= '0;
      timer      <= '0;
      armed      <= 1'b1;
      chg_amt    <= '0;
      quart      <= '0;
      dim        <= '0;
      nick       <= '0;
      prev_coins <= {dollar, quarter, dime, nickel};
      prev_index <= index;
      prev_pm    <= paymentMethod;
    end else begin
      prev_coins <= {dollar, quarter, dime, nickel};
      prev_index <= index;
      prev_pm    <= paymentMethod;
      if (vend)        stock[sel] <= stock[sel] - 3'd1;
      if (credit_vend) credit <= credit - {1'b0, price};
      if (chg_set)     chg_amt <= chg_val;
      if (changed)      armed <= 1'b1;
      else if (arm_clr) armed <= 1'b0;
      if (state == CHANGE)  cash <= '0;
      else if (coin_ok)     cash <= cash + coin_sum;
      if (state == CHANGE || coin_ok) timer <= '0;
      else if (state == COLLECT)      timer <= timer + 1'b1;
      if (state == CHANGE) begin
        quart <= cm_q;
        dim   <= cm_d;
        nick  <= cm_n;
      end
    end
  end

endmodule

// File: tb/tb_vending_machine.sv
// Directed bench for vending_machine: scoreboard of expected vend count and change per transaction.
module tb_vending_machine;
  import vending_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  se = '0;
  logic [5:0]  si = '0;
  logic [3:0]  index;
  logic        paymentMethod;
  logic [8:0]  creditBalance;
  logic        nickel, dime, quarter, dollar;
  logic [63:0] cost;
  logic        cancel;
  logic [23:0] currentInventory;
  logic [8:0]  quart, dim, nick;
  logic        dispensed;

  int checks = 0;
  int errors = 0;
  int disp_total = 0;
  int base = 0;

  // Scoreboard entry: {vend count[1:0], quart, dim, nick}
  logic [28:0] exp_q[$];

  vending_machine #(.TIMEOUT_CYCLES(40)) dut (
    .clk              (clk),
    .rst              (rst),
    .se               (se),
    .si               (si),
    .index            (index),
    .paymentMethod    (paymentMethod),
    .creditBalance    (creditBalance),
    .nickel           (nickel),
    .dime             (dime),
    .quarter          (quarter),
    .dollar           (dollar),
    .cost             (cost),
    .cancel           (cancel),
    .currentInventory (currentInventory),
    .quart            (quart),
    .dim              (dim),
    .nick             (nick),
    .dispensed        (dispensed)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dispensed) disp_total++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  // which: 0 nickel, 1 dime, 2 quarter, 3 dollar
  task automatic coin(input int which);
    case (which)
      0: nickel  = 1'b1;
      1: dime    = 1'b1;
      2: quarter = 1'b1;
      default: dollar = 1'b1;
    endcase
    tick();
    nickel = 1'b0; dime = 1'b0; quarter = 1'b0; dollar = 1'b0;
    tick();
  endtask

  task automatic push_exp(input logic [1:0] cnt, input logic [8:0] q, input logic [8:0] d,
                          input logic [8:0] n);
    base = disp_total;
    exp_q.push_back({cnt, q, d, n});
  endtask

  task automatic wait_txn(input string tag);
    logic [28:0] obs;
    logic [28:0] exp_v;
    int n;
    n = 0;
    while (dut.state != CHANGE && n < 200) begin
      tick();
      n++;
    end
    check({tag, "_reach_change"}, 32'(dut.state), 32'(CHANGE));
    tick();
    obs = {2'(disp_total - base), quart, dim, nick};
    exp_v = exp_q.pop_front();
    check(tag, 32'(obs), 32'(exp_v));
  endtask

  initial begin
    rst = 1'b1;
    index = 4'd2;
    paymentMethod = 1'b1;
    creditBalance = 9'd200;
    nickel = 1'b0; dime = 1'b0; quarter = 1'b0; dollar = 1'b0;
    cancel = 1'b0;
    // p7..p0 prices: 75,110,75,50,200,100,250,75
    cost = {8'd75, 8'd110, 8'd75, 8'd50, 8'd200, 8'd100, 8'd250, 8'd75};
    currentInventory = 24'o44444444;
    tick();
    tick();
    check("rst_quart", 32'(quart), 0);
    check("rst_dim", 32'(dim), 0);
    check("rst_nick", 32'(nick), 0);
    check("rst_dispensed", 32'(dispensed), 0);
    check("rst_state", 32'(dut.state), 32'(IDLE));

    // Credit sale: armed by reset, sells once, coins ignored
    push_exp(2'd1, 9'd0, 9'd0, 9'd0);
    rst = 1'b0;
    wait_txn("credit_sale");
    coin(3);
    coin(2);
    repeat (5) tick();
    check("credit_coins_ignored", 32'(dut.cash), 0);
    check("credit_balance", 32'(dut.credit), 100);
    check("credit_stock2", 32'(dut.stock[2]), 3);
    check("credit_single_vend", 32'(disp_total - base), 1);
    check("credit_idle", 32'(dut.state), 32'(IDLE));

    // Exact cash
    paymentMethod = 1'b0;
    index = 4'd3;
    tick();
    push_exp(2'd1, 9'd0, 9'd0, 9'd0);
    coin(3);
    check("exact_collect", 32'(dut.state), 32'(COLLECT));
    check("exact_cash100", 32'(dut.cash), 100);
    repeat (6) tick();
    coin(3);
    wait_txn("exact_cash");
    check("exact_stock3", 32'(dut.stock[3]), 3);

    // Overpay
    index = 4'd6;
    tick();
    push_exp(2'd1, 9'd0, 9'd1, 9'd1);
    coin(3);
    repeat (3) tick();
    check("overpay_no_vend", 32'(disp_total - base), 0);
    check("overpay_collect", 32'(dut.state), 32'(COLLECT));
    coin(2);
    wait_txn("overpay");

    // Cancel refund
    index = 4'd1;
    tick();
    push_exp(2'd0, 9'd5, 9'd1, 9'd1);
    coin(3);
    coin(2);
    coin(1);
    coin(0);
    check("cancel_cash140", 32'(dut.cash), 140);
    cancel = 1'b1;
    wait_txn("cancel_refund");
    cancel = 1'b0;
    tick();

    // Timeout
    push_exp(2'd0, 9'd4, 9'd0, 9'd0);
    coin(3);
    repeat (38) tick();
    check("timeout_still_collect", 32'(dut.state), 32'(COLLECT));
    wait_txn("timeout");

    // Out of stock / invalid selection
    rst = 1'b1;
    currentInventory = 24'o44404444;
    index = 4'd4;
    tick();
    check("rst2_quart", 32'(quart), 0);
    check("rst2_dim", 32'(dim), 0);
    check("rst2_nick", 32'(nick), 0);
    check("rst2_dispensed", 32'(dispensed), 0);
    rst = 1'b0;
    tick();
    check("oos_stock4", 32'(dut.stock[4]), 0);
    push_exp(2'd0, 9'd8, 9'd0, 9'd0);
    coin(3);
    coin(3);
    repeat (5) tick();
    check("oos_collect", 32'(dut.state), 32'(COLLECT));
    cancel = 1'b1;
    wait_txn("out_of_stock");
    cancel = 1'b0;

    index = 4'd9;
    tick();
    push_exp(2'd0, 9'd8, 9'd0, 9'd0);
    coin(3);
    coin(3);
    repeat (5) tick();
    check("invalid_collect", 32'(dut.state), 32'(COLLECT));
    cancel = 1'b1;
    wait_txn("invalid_index");
    cancel = 1'b0;
    tick();

    // Cash cap: the sixth dollar would exceed 500 and is ignored
    push_exp(2'd0, 9'd20, 9'd0, 9'd0);
    for (int i = 0; i < 6; i++) coin(3);
    check("cap_cash500", 32'(dut.cash), 500);
    cancel = 1'b1;
    wait_txn("cash_cap");
    cancel = 1'b0;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
